// File: rtl/pipe_front_regs.sv
// Front-end pipeline registers: fetch PC, IF/ID and the instruction/PC half of ID/EX.
// Applies load-use stall/flush controls and EX-stage redirects; bubbles are canonical NOPs.
module pipe_front_regs #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        pc_en_i,
   input  logic        IF_ID_en_i,
   input  logic        ID_EX_flush_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic [31:0] imem_inst_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_ID_o,
   output logic [31:0] inst_ID_o,
   output logic        valid_ID_o,
   output logic [31:0] pc_EX_o,
   output logic [31:0] inst_EX_o,
   output logic        valid_EX_o,
   output logic [31:0] stall_cnt_o,
   output logic [31:0] flush_cnt_o
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_id_q, pc_id_d;
   logic [31:0] inst_id_q, inst_id_d;
   logic        valid_id_q, valid_id_d;
   logic [31:0] pc_ex_q, pc_ex_d;
   logic [31:0] inst_ex_q, inst_ex_d;
   logic        valid_ex_q, valid_ex_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] flush_cnt_q, flush_cnt_d;
   logic [31:0] redirect_tgt;

   // Targets are forced word-aligned.
   assign redirect_tgt = redirect_pc_i & ~32'h3;

   always_comb begin
      pc_d        = pc_q;
      pc_id_d     = pc_id_q;
      inst_id_d   = inst_id_q;
      valid_id_d  = valid_id_q;
      pc_ex_d     = pc_id_q;
      inst_ex_d   = inst_id_q;
      valid_ex_d  = valid_id_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (redirect_i) begin
         pc_d = redirect_tgt;
      end else if (pc_en_i) begin
         pc_d = pc_q + 32'd4;
      end

      if (redirect_i) begin
         pc_id_d    = 32'h0;
         inst_id_d  = NOP_INST;
         valid_id_d = 1'b0;
      end else if (IF_ID_en_i) begin
         pc_id_d    = pc_q;
         inst_id_d  = imem_inst_i;
         valid_id_d = 1'b1;
      end

      // ID/EX never holds: it either takes IF/ID or a bubble.
      if (redirect_i || ID_EX_flush_i) begin
         pc_ex_d    = 32'h0;
         inst_ex_d  = NOP_INST;
         valid_ex_d = 1'b0;
      end

      if (redirect_i) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end else if (!pc_en_i) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q        <= RESET_PC;
         pc_id_q     <= 32'h0;
         inst_id_q   <= NOP_INST;
         valid_id_q  <= 1'b0;
         pc_ex_q     <= 32'h0;
         inst_ex_q   <= NOP_INST;
         valid_ex_q  <= 1'b0;
         stall_cnt_q <= 32'h0;
         flush_cnt_q <= 32'h0;
      end else begin
         pc_q        <= pc_d;
         pc_id_q     <= pc_id_d;
         inst_id_q   <= inst_id_d;
         valid_id_q  <= valid_id_d;
         pc_ex_q     <= pc_ex_d;
         inst_ex_q   <= inst_ex_d;
         valid_ex_q  <= valid_ex_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign pc_o        = pc_q;
   assign pc_ID_o     = pc_id_q;
   assign inst_ID_o   = inst_id_q;
   assign valid_ID_o  = valid_id_q;
   assign pc_EX_o     = pc_ex_q;
   assign inst_EX_o   = inst_ex_q;
   assign valid_EX_o  = valid_ex_q;
   assign stall_cnt_o = stall_cnt_q;
   assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_pipe_front_regs.sv
// Scoreboard bench for pipe_front_regs: directed scenarios plus randomized control traffic.
module tb_pipe_front_regs;

   localparam logic [31:0] RST_PC = 32'h0000_0100;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        pc_en_i = 1'b0, IF_ID_en_i = 1'b0, ID_EX_flush_i = 1'b0, redirect_i = 1'b0;
   logic [31:0] redirect_pc_i = 32'h0;
   logic [31:0] imem_inst_i;
   logic [31:0] pc_o, pc_ID_o, inst_ID_o, pc_EX_o, inst_EX_o, stall_cnt_o, flush_cnt_o;
   logic        valid_ID_o, valid_EX_o;

   pipe_front_regs #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .pc_en_i(pc_en_i), .IF_ID_en_i(IF_ID_en_i),
      .ID_EX_flush_i(ID_EX_flush_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .imem_inst_i(imem_inst_i), .pc_o(pc_o), .pc_ID_o(pc_ID_o), .inst_ID_o(inst_ID_o),
      .valid_ID_o(valid_ID_o), .pc_EX_o(pc_EX_o), .inst_EX_o(inst_EX_o), .valid_EX_o(valid_EX_o),
      .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   // Instruction memory: each word encodes its own address.
   assign imem_inst_i = 32'hAA00_0000 + pc_o;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
   } stage_t;

   typedef struct packed {
      logic [31:0] pc;
      stage_t      id;
      stage_t      ex;
      logic [31:0] stalls;
      logic [31:0] flushes;
   } snap_t;

   snap_t m;
   snap_t exp_q[$];
   int    n_checks = 0;
   int    n_pass = 0;

   function automatic stage_t bubble();
      stage_t b;
      b.pc = 32'h0; b.inst = NOP; b.valid = 1'b0;
      return b;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   task automatic model_reset();
      m.pc = RST_PC; m.id = bubble(); m.ex = bubble(); m.stalls = 0; m.flushes = 0;
   endtask

   // Apply controls for the coming edge and queue the state expected after it.
   task automatic drive(input logic en, input logic ifid, input logic fl, input logic rd,
                        input logic [31:0] tgt);
      snap_t  n;
      stage_t fetched;
      pc_en_i = en; IF_ID_en_i = ifid; ID_EX_flush_i = fl; redirect_i = rd; redirect_pc_i = tgt;
      fetched.pc = m.pc; fetched.inst = 32'hAA00_0000 + m.pc; fetched.valid = 1'b1;
      n = m;
      n.ex = (rd || fl) ? bubble() : m.id;
      n.id = rd ? bubble() : (ifid ? fetched : m.id);
      n.pc = rd ? {tgt[31:2], 2'b00} : (en ? m.pc + 32'd4 : m.pc);
      if (rd) n.flushes = m.flushes + 1;
      else if (!en) n.stalls = m.stalls + 1;
      exp_q.push_back(n);
      m = n;
   endtask

   task automatic step(input logic en, input logic ifid, input logic fl, input logic rd,
                       input logic [31:0] tgt);
      @(negedge clk_i);
      drive(en, ifid, fl, rd, tgt);
   endtask

   task automatic settle();
      @(posedge clk_i);
      #2;
   endtask

   always begin
      snap_t e;
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("sb_pc",       pc_o,        e.pc);
         chk("sb_pc_id",    pc_ID_o,     e.id.pc);
         chk("sb_inst_id",  inst_ID_o,   e.id.inst);
         chk("sb_valid_id", {31'h0, valid_ID_o}, {31'h0, e.id.valid});
         chk("sb_pc_ex",    pc_EX_o,     e.ex.pc);
         chk("sb_inst_ex",  inst_EX_o,   e.ex.inst);
         chk("sb_valid_ex", {31'h0, valid_EX_o}, {31'h0, e.ex.valid});
         chk("sb_stall",    stall_cnt_o, e.stalls);
         chk("sb_flush",    flush_cnt_o, e.flushes);
      end
   end

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"},       pc_o,        RST_PC);
      chk({tag, "_inst_id"},  inst_ID_o,   NOP);
      chk({tag, "_inst_ex"},  inst_EX_o,   NOP);
      chk({tag, "_pc_id"},    pc_ID_o,     32'h0);
      chk({tag, "_pc_ex"},    pc_EX_o,     32'h0);
      chk({tag, "_valids"},   {30'h0, valid_ID_o, valid_EX_o}, 32'h0);
      chk({tag, "_stall"},    stall_cnt_o, 32'h0);
      chk({tag, "_flush"},    flush_cnt_o, 32'h0);
   endtask

   initial begin
      logic en, ifid, fl, rd;
      model_reset();
      repeat (2) @(negedge clk_i);
      chk_reset_vals("reset");

      @(negedge clk_i);
      rst_ni = 1'b1;
      drive(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      settle();
      chk("run_pc",      pc_o,      32'h0000_010C);
      chk("run_inst_id", inst_ID_o, 32'hAA00_0108);
      chk("run_inst_ex", inst_EX_o, 32'hAA00_0104);
      chk("run_valid_ex", {31'h0, valid_EX_o}, 32'h1);

      step(1, 1, 0, 1, 32'h0000_0407);
      settle();
      chk("redir_pc",     pc_o,        32'h0000_0404);
      chk("redir_valids", {30'h0, valid_ID_o, valid_EX_o}, 32'h0);
      chk("redir_inst_id", inst_ID_o,  NOP);
      chk("redir_inst_ex", inst_EX_o,  NOP);
      chk("redir_flush",  flush_cnt_o, 32'h1);
      step(1, 1, 0, 0, 0);
      settle();
      chk("redir_pc_id",  pc_ID_o,     32'h0000_0404);

      step(1, 1, 0, 1, 32'h0000_001C);
      step(1, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      settle();
      chk("stall_pc",      pc_o,        32'h0000_0020);
      chk("stall_pc_id",   pc_ID_o,     32'h0000_001C);
      chk("stall_inst_id", inst_ID_o,   32'hAA00_001C);
      chk("stall_inst_ex", inst_EX_o,   NOP);
      chk("stall_valid_ex", {31'h0, valid_EX_o}, 32'h0);
      chk("stall_cnt",     stall_cnt_o, 32'h1);
      step(1, 1, 0, 0, 0);
      settle();
      chk("stall_dep_ex",  inst_EX_o,   32'hAA00_001C);

      step(0, 0, 1, 1, 32'h0000_0080);
      settle();
      chk("both_pc",      pc_o,        32'h0000_0080);
      chk("both_inst_id", inst_ID_o,   NOP);
      chk("both_inst_ex", inst_EX_o,   NOP);
      chk("both_stall",   stall_cnt_o, 32'h1);
      chk("both_flush",   flush_cnt_o, 32'h3);

      step(1, 1, 0, 1, 32'hFFFF_FFFC);
      step(1, 1, 0, 0, 0);
      settle();
      chk("wrap_pc", pc_o, 32'h0000_0000);

      for (int i = 0; i < 400; i++) begin
         en   = ($urandom_range(0, 4) != 0);
         ifid = ($urandom_range(0, 7) == 0) ? ~en : en;
         fl   = ($urandom_range(0, 5) == 0) || !en;
         rd   = ($urandom_range(0, 9) == 0);
         step(en, ifid, fl, rd, $urandom);
      end

      step(0, 0, 1, 0, 0);
      settle();
      #1;
      rst_ni = 1'b0;
      #1;
      chk_reset_vals("async");
      model_reset();
      @(negedge clk_i);
      rst_ni = 1'b1;
      drive(1, 1, 0, 0, 0);
      step(1, 1, 0, 0, 0);
      settle();
      chk("post_rst_inst_ex", inst_EX_o, 32'hAA00_0100);
      chk("sb_drained", exp_q.size(), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pipe_front_regs.md
# pipe_front_regs

Front-end pipeline state for the forwarding pipeline. Holds the PC, the IF/ID register and the instruction/PC fields of the ID/EX register. It consumes the load-use stall and flush controls (`pc_en`, `IF_ID_en`, `ID_EX_flush`) and the EX-stage branch/jump redirect. Its `inst_EX_o` output feeds back to the load-use hazard detector. Bubbles it inserts are canonical NOPs, so a bubble in EX never looks like a load.

## Interface
- `RESET_PC`, default `32'h0000_0000`: PC value after reset.
- `NOP_INST`, default `32'h0000_0013` (`addi x0,x0,0`): bubble encoding.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `pc_en_i` in 1: advance the PC; 0 holds it (load-use stall).
- `IF_ID_en_i` in 1: load the IF/ID register; 0 holds it.
- `ID_EX_flush_i` in 1: load a bubble into ID/EX.
- `redirect_i` in 1: taken branch/jump resolved in EX.
- `redirect_pc_i` in 32: redirect target.
- `imem_inst_i` in 32: instruction memory read data for `pc_o`, combinational, same cycle.
- `pc_o` out 32: current fetch PC.
- `pc_ID_o`, `inst_ID_o` out 32 each: IF/ID contents.
- `valid_ID_o` out 1: IF/ID holds a real instruction.
- `pc_EX_o`, `inst_EX_o` out 32 each: ID/EX contents.
- `valid_EX_o` out 1: ID/EX holds a real instruction.
- `stall_cnt_o` out 32: count of stall cycles.
- `flush_cnt_o` out 32: count of redirect cycles.

## Operation
- **Reset** (`rst_ni` = 0, asynchronous):
  - `pc_o` = `RESET_PC`.
  - `inst_ID_o` = `inst_EX_o` = `NOP_INST`.
  - `pc_ID_o` = `pc_EX_o` = 0.
  - Both valids = 0; both counters = 0.
  - Reset asserted mid-stall or mid-redirect discards all in-flight state.
- **PC update**, highest priority first:
  - `redirect_i`: PC ← `{redirect_pc_i[31:2], 2'b00}`.
  - else `pc_en_i`: PC ← PC + 4, modulo 2^32 (`32'hFFFF_FFFC` wraps to `32'h0`).
  - else: hold.
- **IF/ID update**, priority order:
  - `redirect_i`: inst ← `NOP_INST`, pc ← 0, valid ← 0.
  - else `IF_ID_en_i`: inst ← `imem_inst_i`, pc ← `pc_o`, valid ← 1.
  - else: hold all three.
- **ID/EX update**, priority order:
  - `redirect_i` or `ID_EX_flush_i`: inst ← `NOP_INST`, pc ← 0, valid ← 0.
  - else: inst/pc/valid ← IF/ID contents. ID/EX never holds.
- **Simultaneous redirect and load-use stall**: redirect wins on every register. Both IF/ID and ID/EX are squashed and the PC takes the target. This case is architecturally impossible (a branch and a load cannot both be in EX) but must be deterministic.
- **Counters**, both wrap modulo 2^32, no saturation:
  - `stall_cnt_o` += 1 on each edge with `pc_en_i` = 0 and `redirect_i` = 0.
  - `flush_cnt_o` += 1 on each edge with `redirect_i` = 1.
- **Stall inputs**: `pc_en_i` and `IF_ID_en_i` are normally equal. The block treats them independently.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- First fetch:
  - Edge 1 after reset release: IF/ID captures the instruction at `RESET_PC`.
  - Edge 2: that instruction reaches EX.
- Load-use stall (one-cycle pulse of `pc_en_i` = `IF_ID_en_i` = 0, `ID_EX_flush_i` = 1):
  - PC and IF/ID hold for exactly one edge.
  - EX holds a NOP for that cycle.
  - The dependent instruction enters EX one edge later.
- Redirect: `redirect_i` is sampled at edge N.
  - At edge N: `pc_o` = target, ID and EX both invalid (2-cycle penalty).
  - Edge N+1: the target instruction is in ID.
- Repeated stalls hold state indefinitely. `stall_cnt_o` increments once per held cycle.

## Test plan
- **Reset then free run**: `RESET_PC` = `0x100`, enables = 1, memory returns `0xAA00_0000`+pc.
  - After 3 edges: `pc_o` = `0x10C`, `inst_ID_o` = `0xAA00_0108`, `inst_EX_o` = `0xAA00_0104`, `valid_EX_o` = 1.
- **Load-use stall**: one cycle with `pc_en`/`IF_ID_en` = 0 and `ID_EX_flush` = 1, with `pc_o` = `0x20`.
  - Next cycle: `pc_o` = `0x20`, IF/ID unchanged, `inst_EX_o` = `0x0000_0013`, `valid_EX_o` = 0, `stall_cnt_o` = 1.
- **Redirect**: `redirect_pc_i` = `0x0000_0407`.
  - Next cycle: `pc_o` = `0x404`, both valids = 0, both insts = NOP, `flush_cnt_o` = 1.
  - Following cycle: `pc_ID_o` = `0x404`.
- **Simultaneous redirect and stall**: assert all four controls, target `0x80`.
  - Next cycle: `pc_o` = `0x80`, both stages NOP, `stall_cnt_o` unchanged, `flush_cnt_o` incremented.
- **PC wrap**: PC = `0xFFFF_FFFC` with `pc_en` = 1.
  - Next cycle: `pc_o` = `0x0000_0000`.
- **Async reset mid-stall**: drop `rst_ni` between clock edges while stalled.
  - Outputs go to reset values immediately, without waiting for a clock edge; counters = 0.
